// File: rtl/led_pio_blink_pkg.sv
// led_pio_pkg: constants shared by the LED PIO blink block.
//   - Word addresses of the slave register map.
//   - Reset values of BLINK_HALF and DUTY.
package led_pio_pkg;

   localparam logic [2:0] ADDR_DATA       = 3'd0;
   localparam logic [2:0] ADDR_MODE       = 3'd1;
   localparam logic [2:0] ADDR_BLINK_HALF = 3'd2;
   localparam logic [2:0] ADDR_STATUS     = 3'd3;
   localparam logic [2:0] ADDR_OUTSET     = 3'd4;
   localparam logic [2:0] ADDR_OUTCLEAR   = 3'd5;
   localparam logic [2:0] ADDR_DUTY       = 3'd6;
   localparam logic [2:0] ADDR_RSVD       = 3'd7;

   localparam int unsigned BLINK_HALF_RST = 500;
   localparam logic [7:0]  DUTY_RST       = 8'hFF;

endpackage

// File: rtl/led_pio_blink_if.sv
// led_pio_blink_if: Avalon-MM slave bus of the LED PIO.
//   address    word address (3 bits)
//   chipselect slave select
//   write_n    active-low write strobe
//   writedata  32-bit write data
//   readdata   32-bit read data, combinational from address
// Modports: master (interconnect / bench side), slave (PIO side).
interface led_pio_blink_if;

   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output address,
      output chipselect,
      output write_n,
      output writedata,
      input  readdata
   );

   modport slave (
      input  address,
      input  chipselect,
      input  write_n,
      input  writedata,
      output readdata
   );

endinterface

// File: rtl/led_pio_tick_gen.sv
// led_pio_tick_gen: blink timebase.
//   Prescaler counts 0..PRESCALE-1 and ticks on wrap; a half-period counter
//   advances per tick and toggles the shared blink phase after
//   max(half_period,1) ticks.
// Ports:
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   half_period  BLINK_HALF register value (0 behaves as 1)
//   restart      clears prescaler and half-period counter, phase held
//   phase        current blink phase
module led_pio_tick_gen
   import led_pio_pkg::*;
#(
   parameter int unsigned PRESCALE = 50000,
   parameter int unsigned PERIOD_W = 16
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [PERIOD_W-1:0] half_period,
   input  logic                restart,
   output logic                phase
);

   localparam int unsigned    PsW   = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
   localparam logic [PsW-1:0] PsMax = PsW'(PRESCALE - 1);

   logic [PsW-1:0]      pre_q, pre_d;
   logic [PERIOD_W-1:0] hcnt_q, hcnt_d;
   logic [PERIOD_W-1:0] half_max;
   logic                phase_q, phase_d;
   logic                tick;

   always_comb begin
      tick     = (pre_q == PsMax);
      half_max = (half_period == '0) ? '0 : half_period - PERIOD_W'(1);
      pre_d    = tick ? '0 : pre_q + PsW'(1);
      hcnt_d   = hcnt_q;
      phase_d  = phase_q;
      if (tick) begin
         // >= keeps the counter bounded even if the limit shrinks under it
         if (hcnt_q >= half_max) begin
            hcnt_d  = '0;
            phase_d = ~phase_q;
         end else begin
            hcnt_d = hcnt_q + PERIOD_W'(1);
         end
      end
      // A BLINK_HALF write restarts the timebase but never moves the phase
      if (restart) begin
         pre_d   = '0;
         hcnt_d  = '0;
         phase_d = phase_q;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pre_q   <= '0;
         hcnt_q  <= '0;
         phase_q <= 1'b0;
      end else begin
         pre_q   <= pre_d;
         hcnt_q  <= hcnt_d;
         phase_q <= phase_d;
      end
   end

   assign phase = phase_q;

endmodule

// File: rtl/led_pio_blink.sv
// led_pio_blink: Avalon-MM LED PIO with atomic set/clear and per-bit blink.
// Optional global PWM brightness stage (DUTY register at address 6) is built
// when LED_PIO_BLINK_PWM_EN is defined; otherwise address 6 reads 0.
// Ports:
//   clk       system clock
//   reset_n   asynchronous active-low reset
//   bus       Avalon-MM slave (led_pio_blink_if.slave)
//   out_port  registered LED outputs, WIDTH bits
module led_pio_blink
   import led_pio_pkg::*;
#(
   parameter int unsigned      WIDTH       = 4,
   parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b1}},
   parameter int unsigned      PRESCALE    = 50000,
   parameter int unsigned      PERIOD_W    = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   led_pio_blink_if.slave   bus,
   output logic [WIDTH-1:0] out_port
);

   logic [WIDTH-1:0]    data_q, data_d;
   logic [WIDTH-1:0]    mode_q, mode_d;
   logic [PERIOD_W-1:0] half_q, half_d;
   logic [WIDTH-1:0]    out_q, out_d;
   logic [WIDTH-1:0]    wd;
   logic [31:0]         rdata;
   logic                wr_en;
   logic                restart;
   logic                phase;
   logic                pwm_gate;
   logic                unused_wd;

   assign wr_en     = bus.chipselect & ~bus.write_n;
   assign wd        = bus.writedata[WIDTH-1:0];
   assign unused_wd = ^bus.writedata;

`ifdef LED_PIO_BLINK_PWM_EN
   logic [7:0] duty_q, duty_d;
   logic [7:0] pwm_cnt_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         duty_q    <= DUTY_RST;
         pwm_cnt_q <= '0;
      end else begin
         duty_q    <= duty_d;
         pwm_cnt_q <= pwm_cnt_q + 8'd1;
      end
   end

   // 255 means fully on; otherwise on for DUTY of every 256 cycles
   assign pwm_gate = (duty_q == 8'hFF) | (pwm_cnt_q < duty_q);
`else
   assign pwm_gate = 1'b1;
`endif

   // Register writes
   always_comb begin
      data_d  = data_q;
      mode_d  = mode_q;
      half_d  = half_q;
      restart = 1'b0;
`ifdef LED_PIO_BLINK_PWM_EN
      duty_d  = duty_q;
`endif
      if (wr_en) begin
         case (bus.address)
            ADDR_DATA:     data_d = wd;
            ADDR_MODE:     mode_d = wd;
            ADDR_BLINK_HALF: begin
               half_d  = bus.writedata[PERIOD_W-1:0];
               restart = 1'b1;
            end
            ADDR_OUTSET:   data_d = data_q | wd;
            ADDR_OUTCLEAR: data_d = data_q & ~wd;
`ifdef LED_PIO_BLINK_PWM_EN
            ADDR_DUTY:     duty_d = bus.writedata[7:0];
`endif
            default: ;
         endcase
      end
   end

   // Read mux, zero latency
   always_comb begin
      rdata = '0;
      case (bus.address)
         ADDR_DATA:       rdata[WIDTH-1:0]    = data_q;
         ADDR_MODE:       rdata[WIDTH-1:0]    = mode_q;
         ADDR_BLINK_HALF: rdata[PERIOD_W-1:0] = half_q;
         ADDR_STATUS:     rdata[0]            = phase;
`ifdef LED_PIO_BLINK_PWM_EN
         ADDR_DUTY:       rdata[7:0]          = duty_q;
`endif
         default: ;
      endcase
   end

   assign bus.readdata = rdata;

   // Blinking bits follow the phase; steady bits pass DATA through
   assign out_d = data_q & (~mode_q | {WIDTH{phase}}) & {WIDTH{pwm_gate}};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_q <= RESET_VALUE;
         mode_q <= '0;
         half_q <= PERIOD_W'(BLINK_HALF_RST);
         out_q  <= RESET_VALUE;
      end else begin
         data_q <= data_d;
         mode_q <= mode_d;
         half_q <= half_d;
         out_q  <= out_d;
      end
   end

   assign out_port = out_q;

   led_pio_tick_gen #(
      .PRESCALE (PRESCALE),
      .PERIOD_W (PERIOD_W)
   ) u_tick_gen (
      .clk         (clk),
      .reset_n     (reset_n),
      .half_period (half_q),
      .restart     (restart),
      .phase       (phase)
   );

endmodule

// File: tb/tb_led_pio_blink.sv
// tb_led_pio_blink: directed bench for led_pio_blink (WIDTH=4, PRESCALE=4).
// Covers reset values, register map, atomic set/clear, blink timing,
// BLINK_HALF=0 with restart, asynchronous reset and, when
// LED_PIO_BLINK_PWM_EN is defined, the PWM duty stage.
module tb_led_pio_blink;
   import led_pio_pkg::*;

   localparam int unsigned WIDTH    = 4;
   localparam int unsigned PRESCALE = 4;

   logic             clk;
   logic             reset_n;
   logic [WIDTH-1:0] out_port;
   int               checks;
   int               errors;

   led_pio_blink_if bus ();

   led_pio_blink #(
      .WIDTH       (WIDTH),
      .RESET_VALUE (4'hF),
      .PRESCALE    (PRESCALE),
      .PERIOD_W    (16)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .bus      (bus.slave),
      .out_port (out_port)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not complete, got timeout required finish");
      $fatal(1);
   end

   typedef struct {
      bit          is_wr;
      logic [2:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp;
      string       name;
   } vec_t;

   vec_t vecs_rst[$];
   vec_t vecs_reg[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      @(negedge clk);
      bus.address    = a;
      bus.writedata  = d;
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b0;
      @(negedge clk);
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
   endtask

   task automatic rd(input logic [2:0] a, output logic [31:0] d);
      bus.address    = a;
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b1;
      #1;
      d = bus.readdata;
   endtask

   task automatic apply(input vec_t v);
      logic [31:0] d;
      if (v.is_wr) begin
         wr(v.addr, v.wdata);
      end else begin
         rd(v.addr, d);
         check(v.name, d, v.exp);
      end
   endtask

   // Entry m is sampled after the m-th edge past the restarting write.
   task automatic run_blink(input int n, input logic p0, input int half_eff);
      int          per;
      logic        ep;
      logic        eo;
      logic [31:0] d;
      per = PRESCALE * half_eff;
      for (int m = 1; m <= n; m++) begin
         @(negedge clk);
         ep = p0 ^ (((m / per) % 2) == 1);
         eo = p0 ^ ((((m - 1) / per) % 2) == 1);
         rd(ADDR_STATUS, d);
         check("status_phase", d, {31'b0, ep});
         check("blink_out", {28'b0, out_port}, {28'b0, 3'b111, eo});
      end
   endtask

`ifdef LED_PIO_BLINK_PWM_EN
   task automatic pwm_count(input logic [7:0] duty, input int exp_high);
      int high;
      wr(ADDR_DUTY, {24'b0, duty});
      repeat (3) @(negedge clk);
      high = 0;
      for (int i = 0; i < 256; i++) begin
         @(negedge clk);
         if (out_port[0]) high++;
      end
      check("pwm_high_cycles", high, exp_high);
   endtask
`endif

   initial begin
      logic [31:0] d;
      checks = 0;
      errors = 0;

      vecs_rst.push_back('{1'b0, ADDR_DATA,       32'h0, 32'hF,   "rst_data"});
      vecs_rst.push_back('{1'b0, ADDR_MODE,       32'h0, 32'h0,   "rst_mode"});
      vecs_rst.push_back('{1'b0, ADDR_BLINK_HALF, 32'h0, 32'd500, "rst_blink_half"});
      vecs_rst.push_back('{1'b0, ADDR_STATUS,     32'h0, 32'h0,   "rst_status"});
      vecs_rst.push_back('{1'b0, ADDR_OUTSET,     32'h0, 32'h0,   "rst_outset_rd"});
      vecs_rst.push_back('{1'b0, ADDR_RSVD,       32'h0, 32'h0,   "rst_rsvd"});
`ifdef LED_PIO_BLINK_PWM_EN
      vecs_rst.push_back('{1'b0, ADDR_DUTY,       32'h0, 32'hFF,  "rst_duty"});
`else
      vecs_rst.push_back('{1'b0, ADDR_DUTY,       32'h0, 32'h0,   "rst_addr6"});
`endif

      vecs_reg.push_back('{1'b0, ADDR_OUTSET,     32'h0,        32'h0,    "outset_rd"});
      vecs_reg.push_back('{1'b0, ADDR_OUTCLEAR,   32'h0,        32'h0,    "outclear_rd"});
      vecs_reg.push_back('{1'b1, ADDR_DATA,       32'hFFFFFFF0, 32'h0,    ""});
      vecs_reg.push_back('{1'b0, ADDR_DATA,       32'h0,        32'h0,    "data_upper_ignored"});
      vecs_reg.push_back('{1'b1, ADDR_MODE,       32'hFFFFFFFA, 32'h0,    ""});
      vecs_reg.push_back('{1'b0, ADDR_MODE,       32'h0,        32'hA,    "mode_rw"});
      vecs_reg.push_back('{1'b1, ADDR_MODE,       32'h0,        32'h0,    ""});
      vecs_reg.push_back('{1'b1, ADDR_RSVD,       32'hFF,       32'h0,    ""});
      vecs_reg.push_back('{1'b0, ADDR_DATA,       32'h0,        32'h0,    "rsvd_write_ignored"});
      vecs_reg.push_back('{1'b0, ADDR_RSVD,       32'h0,        32'h0,    "rsvd_rd"});
      vecs_reg.push_back('{1'b1, ADDR_BLINK_HALF, 32'h12345,    32'h0,    ""});
      vecs_reg.push_back('{1'b0, ADDR_BLINK_HALF, 32'h0,        32'h2345, "blink_half_trunc"});
      vecs_reg.push_back('{1'b1, ADDR_OUTSET,     32'hF,        32'h0,    ""});
      vecs_reg.push_back('{1'b0, ADDR_DATA,       32'h0,        32'hF,    "outset_all"});
      vecs_reg.push_back('{1'b1, ADDR_OUTCLEAR,   32'hFFFFFFF9, 32'h0,    ""});
      vecs_reg.push_back('{1'b0, ADDR_DATA,       32'h0,        32'h6,    "outclear_mask"});

      bus.address    = '0;
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
      bus.writedata  = '0;
      reset_n        = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_out_in_reset", {28'b0, out_port}, 32'hF);
      reset_n = 1'b1;
      @(negedge clk);
      check("rst_out", {28'b0, out_port}, 32'hF);
      foreach (vecs_rst[i]) apply(vecs_rst[i]);

      // Atomic ops: DATA 0x5 -> |0x2 = 0x7 -> &~0x4 = 0x3, out one edge later
      wr(ADDR_DATA, 32'h5);
      wr(ADDR_OUTSET, 32'h2);
      wr(ADDR_OUTCLEAR, 32'h4);
      check("atomic_out_lag", {28'b0, out_port}, 32'h7);
      @(negedge clk);
      check("atomic_out", {28'b0, out_port}, 32'h3);
      rd(ADDR_DATA, d);
      check("atomic_data", d, 32'h3);

      foreach (vecs_reg[i]) apply(vecs_reg[i]);

      // Blink: bit0 toggles every PRESCALE*3 = 12 cycles
      wr(ADDR_DATA, 32'hF);
      wr(ADDR_MODE, 32'h1);
      wr(ADDR_BLINK_HALF, 32'd3);
      run_blink(40, 1'b0, 3);

      // BLINK_HALF=0 acts as 1; phase is 1 at this write (toggled at 12/24/36)
      wr(ADDR_BLINK_HALF, 32'd0);
      run_blink(9, 1'b1, 1);
      // Rewrite one cycle before the next tick: count restarts, phase held
      wr(ADDR_BLINK_HALF, 32'd0);
      run_blink(13, 1'b1, 1);

      // Async reset between edges while bit0 is low
      #2;
      reset_n = 1'b0;
      #1;
      check("async_rst_out", {28'b0, out_port}, 32'hF);
      rd(ADDR_STATUS, d);
      check("async_rst_phase", d, 32'h0);
      rd(ADDR_MODE, d);
      check("async_rst_mode", d, 32'h0);
      rd(ADDR_BLINK_HALF, d);
      check("async_rst_half", d, 32'd500);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      wr(ADDR_MODE, 32'h1);
      wr(ADDR_BLINK_HALF, 32'd3);
      run_blink(26, 1'b0, 3);

`ifdef LED_PIO_BLINK_PWM_EN
      wr(ADDR_MODE, 32'h0);
      wr(ADDR_DATA, 32'h1);
      rd(ADDR_DUTY, d);
      check("duty_rst_rd", d, 32'hFF);
      pwm_count(8'd64, 64);
      rd(ADDR_DUTY, d);
      check("duty_rd", d, 32'd64);
      pwm_count(8'd0, 0);
      pwm_count(8'd255, 256);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
